sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO and the next generation of the team's FIFO buffering. It adds programmable almost-full/almost-empty thresholds, an occupancy count, and overflow/underflow error pulses. It also offers a selectable first-word-fall-through (FWFT) read mode. It sits between any producer/consumer pair in one clock domain and is the reference model for the single-clock variant of the FIFO UVM bench.

---
 rtl/sync_fifo_param.sv | 106 ++++++++++
 tb/tb_sync_fifo_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, overflow/underflow pulses and a selectable first-word-fall-through read port.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      i_wData,
    input  logic                       i_wEN,
    input  logic                       i_rEN,
    output logic [DATA_WIDTH-1:0]      o_rData,
    output logic                       o_Full,
    output logic                       o_Empty,
    output logic                       o_AlmostFull,
    output logic                       o_AlmostEmpty,
    output logic [$clog2(DEPTH):0]     o_Count,
    output logic                       o_Overflow,
    output logic                       o_Underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance uses the registered flags, so a full FIFO still accepts a read
    // alongside a rejected write, and an empty one accepts a write alongside a rejected read.
    assign wr_acc = i_wEN && !o_Full;
    assign rd_acc = i_rEN && !o_Empty;

    always_comb begin
        count_next = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_Full        <= 1'b0;
            o_Empty       <= 1'b1;
            o_AlmostFull  <= 1'b0;
            o_AlmostEmpty <= 1'b1;
            o_Overflow    <= 1'b0;
            o_Underflow   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count         <= count_next;
            // Flags come from count_next so they line up with o_Count in the same cycle.
            o_Full        <= (count_next == FULL_CNT);
            o_Empty       <= (count_next == '0);
            o_AlmostFull  <= (count_next >= AF_CNT);
            o_AlmostEmpty <= (count_next <= AE_CNT);
            o_Overflow    <= i_wEN && o_Full;
            o_Underflow   <= i_rEN && o_Empty;
        end
    end

    assign o_Count = count;

    // Storage is deliberately left out of reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= i_wData;
        end
    end

    generate
        if (FWFT == 0) begin : g_std_read
            logic [DATA_WIDTH-1:0] rdata_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (rd_acc) begin
                    rdata_q <= mem[rd_ptr];
                end
            end

            assign o_rData = rdata_q;
        end else begin : g_fwft_read
            // Head word is presented combinationally from registered state; zero when empty.
            assign o_rData = o_Empty ? '0 : mem[rd_ptr];
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-mode and an FWFT instance share one stimulus stream
// and are compared every cycle against a queue-based model, plus literal spot checks.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wdata = 8'h00;
    logic       wen = 1'b0;
    logic       ren = 1'b0;

    logic [7:0] rdata0, rdata1;
    logic       full0, empty0, af0, ae0, ovf0, udf0;
    logic       full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_rd0 = 8'h00;
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .i_wData(wdata), .i_wEN(wen), .i_rEN(ren),
        .o_rData(rdata0), .o_Full(full0), .o_Empty(empty0), .o_AlmostFull(af0),
        .o_AlmostEmpty(ae0), .o_Count(cnt0), .o_Overflow(ovf0), .o_Underflow(udf0)
    );

    sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .i_wData(wdata), .i_wEN(wen), .i_rEN(ren),
        .o_rData(rdata1), .o_Full(full1), .o_Empty(empty1), .o_AlmostFull(af1),
        .o_AlmostEmpty(ae1), .o_Count(cnt1), .o_Overflow(ovf1), .o_Underflow(udf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rd0 = 8'h00;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic r, input logic [7:0] d);
        bit is_full;
        bit is_empty;
        is_full  = (q.size() == 16);
        is_empty = (q.size() == 0);
        m_ovf = w && is_full;
        m_udf = r && is_empty;
        if (r && !is_empty) m_rd0 = q.pop_front();
        if (w && !is_full) q.push_back(d);
    endtask

    // One clock of stimulus; returns 1 time unit after the edge with outputs settled.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        wen = w;
        ren = r;
        wdata = d;
        @(posedge clk);
        model_step(w, r, d);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, 1'b1, 8'h00);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".empty0"}, 32'(empty0), 32'd1);
        chk({tag, ".full0"},  32'(full0),  32'd0);
        chk({tag, ".ae0"},    32'(ae0),    32'd1);
        chk({tag, ".af0"},    32'(af0),    32'd0);
        chk({tag, ".cnt0"},   32'(cnt0),   32'd0);
        chk({tag, ".rdata0"}, 32'(rdata0), 32'd0);
        chk({tag, ".ovf0"},   32'(ovf0),   32'd0);
        chk({tag, ".udf0"},   32'(udf0),   32'd0);
        chk({tag, ".empty1"}, 32'(empty1), 32'd1);
        chk({tag, ".cnt1"},   32'(cnt1),   32'd0);
        chk({tag, ".rdata1"}, 32'(rdata1), 32'd0);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (checking) begin
            int  n;
            bit  e;
            n = q.size();
            e = (n == 0);
            chk("cnt0",   32'(cnt0),   32'(n));
            chk("full0",  32'(full0),  32'(n == 16));
            chk("empty0", 32'(empty0), 32'(e));
            chk("af0",    32'(af0),    32'(n >= 14));
            chk("ae0",    32'(ae0),    32'(n <= 2));
            chk("ovf0",   32'(ovf0),   32'(m_ovf));
            chk("udf0",   32'(udf0),   32'(m_udf));
            chk("rdata0", 32'(rdata0), 32'(m_rd0));
            chk("cnt1",   32'(cnt1),   32'(n));
            chk("full1",  32'(full1),  32'(n == 16));
            chk("empty1", 32'(empty1), 32'(e));
            chk("af1",    32'(af1),    32'(n >= 14));
            chk("ae1",    32'(ae1),    32'(n <= 2));
            chk("ovf1",   32'(ovf1),   32'(m_ovf));
            chk("udf1",   32'(udf1),   32'(m_udf));
            chk("rdata1", 32'(rdata1), e ? 32'd0 : 32'(q[0]));
        end
    end

    initial begin
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;
        chk_reset_values("reset");

        // Fill to full
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i + 1));
            if (i == 12) chk("fill.af_before14", 32'(af0), 32'd0);
            if (i == 13) chk("fill.af_at14", 32'(af0), 32'd1);
            if (i == 14) chk("fill.full_before16", 32'(full0), 32'd0);
        end
        chk("fill.full", 32'(full0), 32'd1);
        chk("fill.cnt", 32'(cnt0), 32'd16);
        cycle(1'b1, 1'b0, 8'hAA);
        chk("fill.ovf", 32'(ovf0), 32'd1);
        chk("fill.cnt_after_ovf", 32'(cnt0), 32'd16);
        cycle(1'b0, 1'b0, 8'h00);
        chk("fill.ovf_one_cycle", 32'(ovf0), 32'd0);

        // Drain to empty
        for (int k = 1; k <= 16; k++) begin
            cycle(1'b0, 1'b1, 8'h00);
            chk("drain.rdata", 32'(rdata0), 32'(k));
            if (k == 13) chk("drain.ae_at3", 32'(ae0), 32'd0);
            if (k == 14) chk("drain.ae_at2", 32'(ae0), 32'd1);
            if (k == 15) chk("drain.empty_at1", 32'(empty0), 32'd0);
        end
        chk("drain.empty", 32'(empty0), 32'd1);
        cycle(1'b0, 1'b1, 8'h00);
        chk("drain.udf", 32'(udf0), 32'd1);
        chk("drain.rdata_hold", 32'(rdata0), 32'h10);
        cycle(1'b0, 1'b0, 8'h00);
        chk("drain.udf_one_cycle", 32'(udf0), 32'd0);

        // FWFT fall-through
        cycle(1'b1, 1'b0, 8'h5A);
        chk("fwft.empty", 32'(empty1), 32'd0);
        chk("fwft.rdata", 32'(rdata1), 32'h5A);
        cycle(1'b0, 1'b1, 8'h00);
        chk("fwft.empty_after_read", 32'(empty1), 32'd1);
        chk("fwft.rdata_zero", 32'(rdata1), 32'd0);
        chk("fwft.std_rdata", 32'(rdata0), 32'h5A);

        // Simultaneous read/write at count 5
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i));
        for (int j = 0; j < 4; j++) begin
            cycle(1'b1, 1'b1, 8'(8'h25 + j));
            chk("simul.cnt", 32'(cnt0), 32'd5);
            chk("simul.rdata", 32'(rdata0), 32'(8'h20 + j));
        end
        drain();
        chk("simul.last", 32'(rdata0), 32'h28);

        // Simultaneous read/write at full
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i));
        cycle(1'b1, 1'b1, 8'hEE);
        chk("fullrw.ovf", 32'(ovf0), 32'd1);
        chk("fullrw.cnt", 32'(cnt0), 32'd15);
        chk("fullrw.rdata", 32'(rdata0), 32'h80);
        chk("fullrw.full", 32'(full0), 32'd0);
        drain();
        chk("fullrw.last", 32'(rdata0), 32'h8F);

        // Pointer wrap with steady occupancy of 3
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b1, 8'(8'h43 + i));
            chk("wrap.rdata", 32'(rdata0), 32'(8'h40 + i));
            chk("wrap.cnt", 32'(cnt0), 32'd3);
        end
        drain();

        // Asynchronous reset between edges at count 9
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i));
        chk("arst.cnt_before", 32'(cnt0), 32'd9);
        wen = 1'b0;
        ren = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_reset_values("arst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, 1'b0, 8'h33);
        chk("arst.cnt1", 32'(cnt0), 32'd1);
        chk("arst.fwft_rdata", 32'(rdata1), 32'h33);
        cycle(1'b0, 1'b1, 8'h00);
        chk("arst.cnt0", 32'(cnt0), 32'd0);
        chk("arst.rdata", 32'(rdata0), 32'h33);
        cycle(1'b0, 1'b0, 8'h00);

        @(negedge clk);
        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
